// File: rtl/misr_pkg.sv
// Shared types and default constants for the MISR signature compactor.
// Imported by misr_next and misr_compactor.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_e;

  localparam logic [15:0] MISR_POLY_CCITT = 16'h1021;
  localparam logic [15:0] MISR_SEED_ZERO  = 16'h0000;

endpackage

// File: rtl/misr_next.sv
// Combinational MISR step: shift with polynomial feedback, then XOR in the
// observed vector folded modulo SIG_W.
module misr_next
  import misr_pkg::*;
#(
  parameter int              SIG_W  = 16,
  parameter int              DATA_W = 10,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY_CCITT
) (
  input  logic [SIG_W-1:0]  sig_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [SIG_W-1:0]  sig_out
);

  logic [SIG_W-1:0] shifted;
  logic [SIG_W-1:0] fold;

  always_comb begin
    shifted = {sig_in[SIG_W-2:0], 1'b0} ^ (sig_in[SIG_W-1] ? POLY : '0);
  end

  // Input bits wider than the register wrap around onto the low stages.
  always_comb begin
    fold = '0;
    for (int k = 0; k < DATA_W; k++) begin
      fold[k % SIG_W] = fold[k % SIG_W] ^ data_in[k];
    end
  end

  assign sig_out = shifted ^ fold;

endmodule

// File: rtl/misr_compactor.sv
// Multiple-input signature register with start/abort control, a pattern-count
// window qualified by data_valid, and a golden-signature compare on completion.
module misr_compactor
  import misr_pkg::*;
#(
  parameter int               SIG_W  = 16,
  parameter int               DATA_W = 10,
  parameter logic [SIG_W-1:0] POLY   = MISR_POLY_CCITT,
  parameter logic [SIG_W-1:0] SEED   = MISR_SEED_ZERO,
  parameter int               CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CNT_W-1:0]  pattern_count,
  input  logic [SIG_W-1:0]  golden,
  output logic [SIG_W-1:0]  signature,
  output logic              busy,
  output logic              done,
  output logic              pass_nfail,
  output logic [1:0]        state_dbg
);

  // Control handshake: start and abort are single-cycle pulses sampled on the
  // rising edge; abort wins over start, start wins over data. data_in is
  // consumed only on edges where busy=1 and data_valid=1. The controller may
  // read pass_nfail whenever done=1; both stay put until abort or a new start.

  misr_state_e      state_q, state_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             pass_q, pass_d;
  logic [SIG_W-1:0] sig_next;

  misr_next #(
    .SIG_W  (SIG_W),
    .DATA_W (DATA_W),
    .POLY   (POLY)
  ) u_next (
    .sig_in  (sig_q),
    .data_in (data_in),
    .sig_out (sig_next)
  );

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    pass_d   = pass_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (start) begin
          state_d  = RUN;
          sig_d    = SEED;
          cnt_d    = '0;
          target_d = pattern_count;
          pass_d   = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (target_q == '0) begin
          // Empty window: finish without touching the seed.
          state_d = DONE;
          pass_d  = (sig_q == golden);
        end else if (data_valid) begin
          sig_d = sig_next;
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (cnt_q == target_q - CNT_W'(1)) begin
            state_d = DONE;
            pass_d  = (sig_next == golden);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pass_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      pass_q   <= pass_d;
    end
  end

  assign signature  = sig_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);
  assign pass_nfail = pass_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_misr_compactor.sv
// Directed bench for misr_compactor: three instances (default, SEED=8000,
// DATA_W=20) share control and each gets its own data vector.
module tb_misr_compactor;
  import misr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic        start = 1'b0, abort = 1'b0, data_valid = 1'b0;
  logic [15:0] pattern_count = '0;
  logic [15:0] golden = '0;
  logic [9:0]  di_a = '0, di_b = '0;
  logic [19:0] di_c = '0;

  logic [15:0] sig_a, sig_b, sig_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic        pass_a, pass_b, pass_c;
  logic [1:0]  st_a, st_b, st_c;

  misr_compactor dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .data_valid(data_valid), .data_in(di_a), .pattern_count(pattern_count),
    .golden(golden), .signature(sig_a), .busy(busy_a), .done(done_a),
    .pass_nfail(pass_a), .state_dbg(st_a)
  );

  misr_compactor #(.SEED(16'h8000)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .data_valid(data_valid), .data_in(di_b), .pattern_count(pattern_count),
    .golden(golden), .signature(sig_b), .busy(busy_b), .done(done_b),
    .pass_nfail(pass_b), .state_dbg(st_b)
  );

  misr_compactor #(.DATA_W(20)) dut_c (
    .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
    .data_valid(data_valid), .data_in(di_c), .pattern_count(pattern_count),
    .golden(golden), .signature(sig_c), .busy(busy_c), .done(done_c),
    .pass_nfail(pass_c), .state_dbg(st_c)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Compares the three signatures against the values queued in exp_q.
  task automatic chk_sigs(input string name);
    logic [31:0] e;
    e = exp_q.pop_front(); chk({name, " sig_a"}, {16'h0, sig_a}, e);
    e = exp_q.pop_front(); chk({name, " sig_b"}, {16'h0, sig_b}, e);
    e = exp_q.pop_front(); chk({name, " sig_c"}, {16'h0, sig_c}, e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] pc, input logic [15:0] gold);
    pattern_count = pc;
    golden        = gold;
    start         = 1'b1;
    step();
    start         = 1'b0;
  endtask

  task automatic send(input logic [9:0] a, input logic [9:0] b, input logic [19:0] c);
    di_a = a; di_b = b; di_c = c;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] golden;
    logic [9:0]  di_a;
    logic [9:0]  di_b;
    logic [19:0] di_c;
    logic [15:0] exp_a, exp_b, exp_c;
    logic        pass_a, pass_b, pass_c;
  } vec_t;

  vec_t vecs[5];

  initial begin
    // Single-vector runs (pattern_count=1), hand-computed.
    vecs[0] = '{16'h0001, 10'h001, 10'h000, 20'h10001, 16'h0001, 16'h1021, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0001, 10'h000, 10'h000, 20'h10000, 16'h0000, 16'h1021, 16'h0001, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{16'h03FF, 10'h3FF, 10'h3FF, 20'hFFFFF, 16'h03FF, 16'h13DE, 16'hFFF0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{16'h1021, 10'h000, 10'h000, 20'h00000, 16'h0000, 16'h1021, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hFFF0, 10'h155, 10'h001, 20'hFFFFF, 16'h0155, 16'h1020, 16'hFFF0, 1'b0, 1'b0, 1'b1};

    // Reset state.
    #12;
    chk("reset sig_a", {16'h0, sig_a}, 32'h0);
    chk("reset sig_b", {16'h0, sig_b}, 32'h0);
    chk("reset busy",  {31'h0, busy_a}, 32'h0);
    chk("reset done",  {31'h0, done_a}, 32'h0);
    chk("reset pass",  {31'h0, pass_b}, 32'h0);
    reset_n = 1'b1;
    step();

    // Table: start, one valid vector, done on the following sample.
    for (int i = 0; i < 5; i++) begin
      pulse_start(16'd1, vecs[i].golden);
      chk($sformatf("v%0d busy after start", i), {31'h0, busy_a}, 32'h1);
      chk($sformatf("v%0d done cleared", i), {31'h0, done_a}, 32'h0);
      chk($sformatf("v%0d pass cleared", i), {29'h0, pass_a, pass_b, pass_c}, 32'h0);
      send(vecs[i].di_a, vecs[i].di_b, vecs[i].di_c);
      exp_q.push_back({16'h0, vecs[i].exp_a});
      exp_q.push_back({16'h0, vecs[i].exp_b});
      exp_q.push_back({16'h0, vecs[i].exp_c});
      chk_sigs($sformatf("v%0d", i));
      chk($sformatf("v%0d done", i), {29'h0, done_a, done_b, done_c}, 32'h7);
      chk($sformatf("v%0d busy", i), {29'h0, busy_a, busy_b, busy_c}, 32'h0);
      chk($sformatf("v%0d pass", i), {29'h0, pass_a, pass_b, pass_c},
          {29'h0, vecs[i].pass_a, vecs[i].pass_b, vecs[i].pass_c});
      chk($sformatf("v%0d state", i), {30'h0, st_a}, {30'h0, DONE});
    end

    // Two valid vectors separated by gaps.
    pulse_start(16'd2, 16'h0003);
    send(10'h001, 10'h000, 20'h0);
    chk("gap sig1", {16'h0, sig_a}, 32'h0001);
    for (int g = 0; g < 3; g++) begin
      step();
      chk($sformatf("gap hold %0d", g), {15'h0, done_a, sig_a}, 32'h0001);
    end
    send(10'h001, 10'h000, 20'h0);
    chk("gap sig2", {16'h0, sig_a}, 32'h0003);
    chk("gap done/pass", {30'h0, done_a, pass_a}, 32'h3);

    // abort together with start in RUN after 1 of 4 vectors.
    pulse_start(16'd4, 16'h0001);
    send(10'h001, 10'h000, 20'h0);
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk("abort sig", {16'h0, sig_a}, 32'h0001);
    chk("abort flags", {29'h0, busy_a, done_a, pass_a}, 32'h0);
    chk("abort state", {30'h0, st_a}, {30'h0, IDLE});
    send(10'h3FF, 10'h3FF, 20'h0);
    chk("idle hold sig", {16'h0, sig_a}, 32'h0001);

    // start in RUN is ignored: no reload, counter keeps going.
    pulse_start(16'd2, 16'h2042);
    send(10'h000, 10'h000, 20'h0);
    chk("run start sig_b", {16'h0, sig_b}, 32'h1021);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run start ignored", {15'h0, busy_b, sig_b}, 32'h11021);
    send(10'h000, 10'h000, 20'h0);
    chk("run start sig2", {16'h0, sig_b}, 32'h2042);
    chk("run start done", {30'h0, done_b, pass_b}, 32'h3);

    // abort in DONE clears done and pass.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("done abort", {29'h0, busy_b, done_b, pass_b}, 32'h0);

    // pattern_count = 0: done one cycle after the start edge.
    pulse_start(16'd0, 16'h8000);
    chk("pc0 busy", {30'h0, busy_b, done_b}, 32'h2);
    step();
    chk("pc0 done", {29'h0, busy_b, done_b, pass_b}, 32'h3);
    chk("pc0 sig_b", {16'h0, sig_b}, 32'h8000);
    chk("pc0 sig_a/pass_a", {15'h0, pass_a, sig_a}, 32'h0);

    // Asynchronous reset mid-run.
    pulse_start(16'd4, 16'h0000);
    send(10'h001, 10'h000, 20'h0);
    #3 reset_n = 1'b0;
    #1;
    chk("arst sig_a", {16'h0, sig_a}, 32'h0);
    chk("arst sig_b", {16'h0, sig_b}, 32'h0);
    chk("arst flags", {29'h0, busy_b, done_b, pass_b}, 32'h0);
    step();
    reset_n = 1'b1;
    step();
    pulse_start(16'd1, 16'h1021);
    chk("post arst seed", {16'h0, sig_b}, 32'h8000);
    send(10'h000, 10'h000, 20'h0);
    chk("post arst run", {13'h0, done_b, pass_b, busy_b, sig_b}, 32'h61021);

    // Asynchronous reset while DONE with pass_nfail=1.
    #3 reset_n = 1'b0;
    #1;
    chk("arst done", {29'h0, busy_b, done_b, pass_b}, 32'h0);
    step();
    reset_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/misr_compactor.md
Name: misr_compactor

Overview:
- Parametrised multiple-input signature register for the scan BIST path.
- Generalises signature width, input width, feedback polynomial and seed.
- Adds start/abort control, a programmable pattern-count window with a data-valid qualifier, a run-time golden-signature input, and a done/pass handshake.
- Sits between the scan-out/observation mux and the BIST controller, which reads busy, done and pass_nfail.

Parameters:
- SIG_W, 16: signature width, ≥ 2.
- DATA_W, 10: observed input vector width, ≥ 1. May exceed SIG_W.
- POLY, 16'h1021: feedback tap mask, SIG_W bits. Bit j set means the MSB feeds stage j.
- SEED, 0: signature value loaded on start, SIG_W bits.
- CNT_W, 16: width of the pattern counter and of pattern_count.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a compaction run.
- abort  in  1  single-cycle pulse; cancels a run.
- data_valid  in  1  qualifies data_in for this cycle.
- data_in  in  DATA_W  observed response vector.
- pattern_count  in  CNT_W  number of valid vectors to compact; sampled on start.
- golden  in  SIG_W  expected signature; sampled on the last update.
- signature  out  SIG_W  current signature register.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass_nfail  out  1  registered compare result; valid while done=1.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; signature=0 (not SEED); counter=0; busy=0; done=0; pass_nfail=0.
- FSM states and transitions:
  - IDLE: signature holds. start → load SEED, clear counter, latch pattern_count as target, go to RUN.
  - RUN: busy=1. Each cycle with data_valid=1: signature <= next(signature, data_in), counter+1. data_valid=0 holds signature and counter.
  - RUN exit: on the valid cycle where counter == target-1, go to DONE. done rises one cycle after that last valid edge. pass_nfail <= (next signature == golden) on the same edge.
  - DONE: done=1, pass_nfail and signature held.
- target=0: go RUN→DONE on the first clock after start, with no update. signature=SEED; pass_nfail=(SEED==golden).
- Priority: abort beats start beats data.
  - abort in RUN → IDLE. signature holds its current value; done=0; pass_nfail=0.
  - abort in IDLE or DONE → IDLE; clears done and pass_nfail.
  - start in RUN is ignored.
  - start in DONE restarts: reload SEED, done=0, pass_nfail=0, go to RUN.
- Next function, all in SIG_W bits:
  - shifted = {sig[SIG_W-2:0],1'b0} XOR (sig[SIG_W-1] ? POLY : 0).
  - fold[j] = XOR of data_in[k] over all k < DATA_W with k mod SIG_W == j. Bits with no source are 0.
  - next = shifted XOR fold.
- Counter saturates at all-ones and never wraps.
- Asynchronous reset mid-run returns immediately to the reset values above. No partial signature is retained.

Decomposition:
- Package misr_pkg:
  - state enum {IDLE, RUN, DONE};
  - default constants MISR_POLY_CCITT = 16'h1021 and MISR_SEED_ZERO.
- Combinational sub-module misr_next, parametrised by SIG_W, DATA_W and POLY. It implements the shift/feedback/fold function, which lets the bench check it standalone against a model.
- misr_compactor holds the FSM, counter, registers and compare.

Test Plan:
- Default params, SEED=0. start with pattern_count=1; one data_valid cycle with data_in=10'h001; golden=16'h0001 → signature=16'h0001, done=1 on the next cycle, pass_nfail=1, busy=0.
- SEED=16'h8000. One valid cycle with data_in=0; golden=16'h0000 → signature=16'h1021 (feedback taps applied), pass_nfail=0, done=1.
- pattern_count=2, data_in=10'h001 on valid cycles separated by 3 cycles of data_valid=0 → signature 16'h0001 then 16'h0003. Holds during gaps; done only after the 2nd valid.
- DATA_W=20, SIG_W=16. One valid with data_in=20'h10001 → bits 0 and 16 fold together, signature=16'h0000. data_in=20'h10000 → 16'h0001.
- Control edges:
  - abort asserted with start in RUN after 1 of 4 vectors → IDLE, signature holds 16'h0001, done=0, pass_nfail=0.
  - start in RUN is ignored.
  - pattern_count=0 → done the cycle after start with signature=SEED.
- reset_n pulsed low mid-RUN, asynchronous to clock → signature, busy, done and pass_nfail go to 0 immediately. A subsequent start runs normally from SEED.
